// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle MIPS-style control FSM (Moore). Every datapath strobe comes
//   straight from a flop: the next state is decoded once, and the strobes for
//   that state are captured on the same edge that enters it.
//
// Parameters
//   MEM_WAIT    : idle cycles between address presentation and valid read
//                 data (1..7); sets the length of FWAIT and LWAIT.
//   EXC_SP_INIT : constant the datapath writes to reg 29 when MemtoReg=2.
//                 The datapath owns the value; it is declared here so one
//                 parameter set configures the whole CPU.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   opcode, funct       : IR[31:26], IR[5:0] (held stable by the IR)
//   Zero, Overflow      : ALU flags (Zero is consumed by the datapath)
//   PCWrite .. EPCControl : 1-bit datapath strobes
//   PCSource  : 0=ALU, 1=ALUOut, 2=jump target, 3=exception vector
//   ALUSrcA   : 0=PC, 1=A
//   ALUSrcB   : 0=B, 1=4, 2=SE(imm), 3=SE(imm)<<2
//   IorD      : 0=PC, 1=ALUOut
//   RegDst    : 0=rt, 1=rd, 2=reg29
//   MemtoReg  : 0=ALUOut, 1=MDR, 2=EXC_SP_INIT
//   ALUOp     : 001 add, 010 sub, 011 and, 100 or, 111 slt
//   ExcSel    : 0=overflow vector, 1=bad-opcode vector
//   Reset     : datapath register reset
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int unsigned MEM_WAIT    = 1,
  parameter int unsigned EXC_SP_INIT = 227
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       MemWrite_Read,
  output logic       IRwrite,
  output logic       RegWrite,
  output logic       AB_Load,
  output logic       MDR_Load,
  output logic       ALUOutCtrl,
  output logic       EPCControl,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUOp,
  output logic       ExcSel,
  output logic       Reset
);

  typedef enum logic [4:0] {
    RST, FETCH, FWAIT, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MADDR, LWAIT, LWB, SWR, BEQ, BNE, JMP, JR, EXC
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       memWriteRead;
    logic       irWrite;
    logic       regWrite;
    logic       abLoad;
    logic       mdrLoad;
    logic       aluOutCtrl;
    logic       epcControl;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       iorD;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [2:0] aluOp;
    logic       excSel;
    logic       dpReset;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wait states count down to zero; zero marks the final (data-valid) cycle.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  // In RST the counter sequences the power-up steps:
  // 0 = reset held / first Reset cycle, 1 = Reset pulse, 2 = reg29 init write.
  localparam logic [2:0] RST_INIT_STEP = 3'd2;

  state_t     state, nextState;
  logic [2:0] count, nextCount;
  logic [2:0] nextAluOp;
  logic       nextExcSel;
  ctrl_t      ctrl;

  // Zero drives the branch decision inside the datapath; EXC_SP_INIT is used
  // by the datapath's MemtoReg mux. Neither affects sequencing here.
  logic        unusedZero;
  logic [31:0] unusedSpInit;
  assign unusedZero   = Zero;
  assign unusedSpInit = EXC_SP_INIT;

  // Strobe decode for one state. EXEC_R's ALU operation and EXC's vector
  // select are chosen on the transition into those states and passed in.
  function automatic ctrl_t decodeCtrl(input state_t     s,
                                       input logic [2:0] cnt,
                                       input logic [2:0] aluOpSel,
                                       input logic       excSelSel);
    ctrl_t c;
    c = '0;
    case (s)
      RST: begin
        if (cnt == RST_INIT_STEP) begin
          c.regWrite = 1'b1;
          c.regDst   = 2'd2;
          c.memtoReg = 2'd2;
        end else begin
          c.dpReset = 1'b1;
        end
      end
      FETCH: begin
        c.pcWrite = 1'b1;
        c.aluSrcB = 2'd1;
        c.aluOp   = ALU_ADD;
      end
      FWAIT:  c.irWrite = (cnt == 3'd0);
      DECODE: begin
        c.abLoad     = 1'b1;
        c.aluOutCtrl = 1'b1;
        c.aluSrcB    = 2'd3;
        c.aluOp      = ALU_ADD;
      end
      EXEC_R: begin
        c.aluSrcA    = 1'b1;
        c.aluOutCtrl = 1'b1;
        c.aluOp      = aluOpSel;
      end
      WB_R: begin
        c.regWrite = 1'b1;
        c.regDst   = 2'd1;
      end
      EXEC_I, MADDR: begin
        c.aluSrcA    = 1'b1;
        c.aluSrcB    = 2'd2;
        c.aluOp      = ALU_ADD;
        c.aluOutCtrl = 1'b1;
      end
      WB_I: c.regWrite = 1'b1;
      LWAIT: begin
        c.iorD    = 1'b1;
        c.mdrLoad = (cnt == 3'd0);
      end
      LWB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 2'd1;
      end
      SWR: begin
        c.iorD         = 1'b1;
        c.memWriteRead = 1'b1;
      end
      BEQ, BNE: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = ALU_SUB;
        c.pcSource    = 2'd1;
        c.pcWriteCond = 1'b1;
      end
      JMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'd2;
      end
      JR: begin
        c.pcWrite = 1'b1;
        c.aluSrcA = 1'b1;
        c.aluOp   = ALU_ADD;
      end
      EXC: begin
        c.epcControl = 1'b1;
        c.pcWrite    = 1'b1;
        c.pcSource   = 2'd3;
        c.excSel     = excSelSel;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    nextState  = state;
    nextCount  = 3'd0;
    nextAluOp  = ALU_ADD;
    nextExcSel = 1'b0;
    case (state)
      RST: begin
        if (count == RST_INIT_STEP) nextState = FETCH;
        else                        nextCount = count + 3'd1;
      end
      FETCH: begin
        nextState = FWAIT;
        nextCount = WAIT_LOAD;
      end
      FWAIT: begin
        if (count == 3'd0) nextState = DECODE;
        else               nextCount = count - 3'd1;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            nextState = EXEC_R;
            case (funct)
              FN_ADD:  nextAluOp = ALU_ADD;
              FN_SUB:  nextAluOp = ALU_SUB;
              FN_AND:  nextAluOp = ALU_AND;
              FN_OR:   nextAluOp = ALU_OR;
              FN_SLT:  nextAluOp = ALU_SLT;
              FN_JR:   nextState = JR;
              default: begin
                nextState  = EXC;
                nextExcSel = 1'b1;
              end
            endcase
          end
          OP_ADDI:      nextState = EXEC_I;
          OP_LW, OP_SW: nextState = MADDR;
          OP_BEQ:       nextState = BEQ;
          OP_BNE:       nextState = BNE;
          OP_J:         nextState = JMP;
          default: begin
            nextState  = EXC;
            nextExcSel = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        // Only add and sub trap; logical ops and slt ignore the flag.
        if (Overflow && (ctrl.aluOp == ALU_ADD || ctrl.aluOp == ALU_SUB))
          nextState = EXC;
        else
          nextState = WB_R;
      end
      EXEC_I:  nextState = Overflow ? EXC : WB_I;
      MADDR: begin
        if (opcode == OP_LW) begin
          nextState = LWAIT;
          nextCount = WAIT_LOAD;
        end else begin
          nextState = SWR;
        end
      end
      LWAIT: begin
        if (count == 3'd0) nextState = LWB;
        else               nextCount = count - 3'd1;
      end
      default: nextState = FETCH;  // WB_R, WB_I, LWB, SWR, BEQ, BNE, JMP, JR, EXC
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST;
      count <= 3'd0;
      ctrl  <= decodeCtrl(RST, 3'd0, ALU_ADD, 1'b0);
    end else begin
      state <= nextState;
      count <= nextCount;
      ctrl  <= decodeCtrl(nextState, nextCount, nextAluOp, nextExcSel);
    end
  end

  assign PCWrite       = ctrl.pcWrite;
  assign PCWriteCond   = ctrl.pcWriteCond;
  assign MemWrite_Read = ctrl.memWriteRead;
  assign IRwrite       = ctrl.irWrite;
  assign RegWrite      = ctrl.regWrite;
  assign AB_Load       = ctrl.abLoad;
  assign MDR_Load      = ctrl.mdrLoad;
  assign ALUOutCtrl    = ctrl.aluOutCtrl;
  assign EPCControl    = ctrl.epcControl;
  assign PCSource      = ctrl.pcSource;
  assign ALUSrcA       = ctrl.aluSrcA;
  assign ALUSrcB       = ctrl.aluSrcB;
  assign IorD          = ctrl.iorD;
  assign RegDst        = ctrl.regDst;
  assign MemtoReg      = ctrl.memtoReg;
  assign ALUOp         = ctrl.aluOp;
  assign ExcSel        = ctrl.excSel;
  assign Reset         = ctrl.dpReset;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning the number of idle cycles between address presentation and valid memory read data (range 1..7).
REQ-002 SHALL have parameter EXC_SP_INIT, default 227, meaning the constant that MemtoReg=2 writes to register 29 at reset.
REQ-003 SHALL have ports in this order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- Overflow  in  1  ALU overflow flag
- PCWrite, PCWriteCond, MemWrite_Read, IRwrite, RegWrite, AB_Load, MDR_Load, ALUOutCtrl, EPCControl  out  1 each  datapath strobes
- PCSource  out  2  0=ALU, 1=ALUOut, 2=jump target, 3=exception vector
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=4, 2=SE(imm), 3=SE(imm)<<2
- IorD  out  1  0=PC, 1=ALUOut
- RegDst  out  2  0=rt, 1=rd, 2=reg29
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=EXC_SP_INIT
- ALUOp  out  3  001 add, 010 sub, 011 and, 100 or, 111 slt
- ExcSel  out  1  0=overflow vector, 1=bad-opcode vector
- Reset  out  1  datapath register reset

Function
REQ-004 SHALL be a Moore FSM; all outputs SHALL be registered, decoded from the current state only, and default to 0 in any state not asserting them.
REQ-005 SHALL implement states RST, FETCH, FWAIT, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MADDR, LWAIT, LWB, SWR, BEQ, BNE, JMP, JR, EXC.
REQ-006 RST SHALL assert Reset for one cycle, then RegWrite=1, RegDst=2, MemtoReg=2 for one cycle, then go to FETCH.
REQ-007 FETCH SHALL drive IorD=0, MemWrite_Read=0, ALUSrcA=0, ALUSrcB=1, ALUOp=001, PCSource=0, PCWrite=1 for exactly one cycle.
REQ-008 FWAIT SHALL last MEM_WAIT cycles via a down-counter and assert IRwrite only on its final cycle.
REQ-009 DECODE SHALL assert AB_Load=1, ALUOutCtrl=1, ALUSrcA=0, ALUSrcB=3, ALUOp=001 and branch on opcode: 0x00 with funct 0x20/0x22/0x24/0x25/0x2A -> EXEC_R; 0x00 with funct 0x08 -> JR; 0x08 -> EXEC_I; 0x23 or 0x2B -> MADDR; 0x04 -> BEQ; 0x05 -> BNE; 0x02 -> JMP; any other -> EXC with ExcSel=1.
REQ-010 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOut load, and ALUOp from funct (add/sub/and/or/slt); if Overflow=1 during add or sub it SHALL go to EXC with ExcSel=0, else to WB_R (RegWrite, RegDst=1, MemtoReg=0).
REQ-011 EXEC_I SHALL use ALUSrcA=1, ALUSrcB=2, ALUOp=001; Overflow=1 -> EXC (ExcSel=0); else WB_I (RegWrite, RegDst=0, MemtoReg=0).
REQ-012 MADDR SHALL compute A+SE(imm) into ALUOut; lw -> LWAIT (IorD=1, MemWrite_Read=0, MEM_WAIT cycles, MDR_Load on the final cycle) -> LWB (RegWrite, RegDst=0, MemtoReg=1); sw -> SWR (IorD=1, MemWrite_Read=1, one cycle).
REQ-013 BEQ/BNE SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=010, PCSource=1, and PCWriteCond=1; the taken condition (Zero for BEQ, !Zero for BNE) SHALL be evaluated by the datapath.
REQ-014 JMP SHALL assert PCWrite with PCSource=2; JR SHALL assert PCWrite with ALUSrcA=1, ALUOp=001, ALUSrcB=0 and the B operand treated as zero by the datapath, with PCSource=0.
REQ-015 EXC SHALL assert EPCControl=1, PCWrite=1, PCSource=3 for one cycle and hold ExcSel; no RegWrite or MemWrite_Read=1 SHALL occur for the faulting instruction.
REQ-016 Every terminal state (WB_R, WB_I, LWB, SWR, BEQ, BNE, JMP, JR, EXC) SHALL return to FETCH.
REQ-017 Overflow and Zero SHALL be ignored in all states except those named in REQ-010, REQ-011 and REQ-013.

Reset
REQ-018 reset=1 on any clock edge SHALL move the FSM to RST, clear the wait counter, and abort any in-flight instruction with no further strobes, including mid-LWAIT and mid-SWR.
REQ-019 While reset is held, outputs SHALL be Reset=1 and all other outputs 0; the sequence of REQ-006 SHALL begin on the first edge after reset deasserts.

Verification
REQ-020 Release reset -> Reset=1 for 1 cycle, then RegWrite=1/RegDst=2/MemtoReg=2 for 1 cycle, then PCWrite=1 in FETCH.
REQ-021 add (op 0x00, funct 0x20), MEM_WAIT=1, Overflow=0 -> 5 cycles FETCH->FWAIT->DECODE->EXEC_R->WB_R, RegWrite=1 with RegDst=1 in cycle 5.
REQ-022 addi with Overflow=1 in EXEC_I -> EXC: EPCControl=1, PCSource=3, ExcSel=0, RegWrite never asserted for that instruction.
REQ-023 lw with MEM_WAIT=3 -> FWAIT lasts 3 cycles, LWAIT lasts 3 cycles with MDR_Load on its 3rd, LWB asserts RegWrite with MemtoReg=1; 10 cycles total.
REQ-024 opcode 0x3F -> DECODE then EXC with ExcSel=1, then FETCH.
REQ-025 reset asserted in the 2nd cycle of LWAIT (MEM_WAIT=3) -> MDR_Load and RegWrite never asserted, and the FSM enters RST on the next edge.
